apb4_slave_regfile: RTL and testbench
=====================================

Name: apb4_slave_regfile

Overview:
Parametrised APB4 slave register file, the next generation of our APB slave. It generalises data width, depth and wait-state count. It adds byte strobes (PSTRB), an error response (PSLVERR) and programmable wait states. It sits behind the APB interconnect as a configurable CSR bank and is driven by the existing APB driver and monitor environment.

Parameters:
DATA_W, 32, data bus width in bits; must be 8, 16, 32 or 64.
ADDR_W, 32, PADDR width in bits.
DEPTH, 16, number of DATA_W registers; power of 2, >= 2.
BASE_ADDR, 0, byte address of register 0; aligned to DEPTH*DATA_W/8.
WAIT_STATES, 0, PREADY-low cycles inserted in ACCESS; range 0 to 15.

Ports:
clk  in  1  clock; all logic on posedge.
RESET  in  1  asynchronous active-high reset.
PADDR  in  ADDR_W  byte address.
PWDATA  in  DATA_W  write data.
PWRITE  in  1  1 = write, 0 = read.
PSELx  in  1  slave select.
PENABLE  in  1  access phase.
PSTRB  in  DATA_W/8  write byte strobes.
PPROT  in  3  protection attributes; used only under the optional feature.
PREADY  out  1  transfer complete.
PRDATA  out  DATA_W  read data.
PSLVERR  out  1  error response; valid only while PREADY=1.

Behaviour:
- Reset (async assert, sync deassert in the system): PREADY=0, PRDATA=0, PSLVERR=0, all registers 0, FSM to IDLE, wait counter 0.
- FSM states:
  - IDLE: waits for PSELx=1 with PENABLE=0.
  - SETUP: addr, wdata, write, strb and prot are captured at that edge; go to ACCESS.
  - ACCESS: on the edge where PREADY=1 and PSELx&PENABLE=1, go to IDLE, or to SETUP if a new setup is presented back-to-back.
- Wait states:
  - The counter loads WAIT_STATES at the SETUP edge.
  - PREADY is registered.
  - With WAIT_STATES=0, PREADY=1 in the first ACCESS cycle, giving a 2-cycle transfer.
  - Otherwise PREADY=0 for exactly WAIT_STATES ACCESS cycles, then 1 for one cycle.
  - PREADY is never held high beyond one cycle.
- Decode:
  - Register index = (PADDR - BASE_ADDR) >> log2(DATA_W/8).
  - Low byte-offset bits are ignored.
  - An address below BASE_ADDR, or at or above BASE_ADDR + DEPTH*DATA_W/8, is out of range.
- Write:
  - Commits at the completing edge (PREADY=1). Only byte lanes with PSTRB[i]=1 update.
  - PSTRB all-zero is a legal no-op with PSLVERR=0.
- Read:
  - PRDATA is loaded with the register value in the same cycle PREADY rises, using the captured address.
  - PRDATA holds until the next read completes. Writes leave PRDATA unchanged.
- Error:
  - Out-of-range access completes normally with PSLVERR=1 in the PREADY cycle.
  - No register changes; PRDATA=0 for reads.
  - PSLVERR=0 whenever PREADY=0.
- Protocol robustness:
  - PENABLE=1 seen in IDLE (no setup) is ignored; no PREADY.
  - PSELx dropping during ACCESS aborts: FSM to IDLE, no write, PREADY/PSLVERR to 0.
- Simultaneous events:
  - A back-to-back setup in the completing cycle is not allowed by APB (PENABLE=1), so the next SETUP is taken the following cycle.
  - A read of a register written in the previous transfer returns the new value.
- Reset mid-transfer: all outputs drop to reset values immediately; the pending write is discarded.

Optional Feature:
APB_PPROT_CHECK_EN.
- Defined: the upper half of the register space (index >= DEPTH/2) is privileged. An access with captured PPROT[0]=0 to that half completes with PSLVERR=1, no write, and PRDATA=0. The lower half is unaffected.
- Undefined: PPROT is ignored (unused input) and all in-range accesses succeed.

Test Plan:
1. Reset, then read each of the 16 registers at byte addresses 0x00 to 0x3C with WAIT_STATES=0 -> PRDATA=0, PSLVERR=0, and PREADY high in the 2nd cycle of every transfer.
2. Write 0xDEADBEEF to 0x08 with PSTRB=4'b1111, then write 0x00000055 with PSTRB=4'b0001, then read 0x08 -> PRDATA=0xDEADBE55.
3. WAIT_STATES=3: write 0x12345678 to 0x04 -> PREADY low for 3 ACCESS cycles, then high for exactly 1; a read of 0x04 returns 0x12345678 after the same latency.
4. Write to 0x40 (out of range at DEPTH=16), then read 0x40 -> PSLVERR=1 and PRDATA=0 in the PREADY cycle; all registers unchanged.
5. Assert RESET during the ACCESS wait cycles of a write of 0xA5A5A5A5 to 0x10 -> PREADY=0 immediately; a read of 0x10 after reset returns 0. Separately, PENABLE=1 with no setup -> no PREADY.
6. With APB_PPROT_CHECK_EN: write 0x1 to 0x20 with PPROT=3'b000 -> PSLVERR=1, register unchanged. The same write with PPROT=3'b001 -> PSLVERR=0, and a read returns 0x1.

Source files
------------

// File: rtl/apb4_slave_regfile.sv
// APB4 slave register file: DEPTH x DATA_W registers with byte strobes,
// out-of-range error response and a fixed number of wait states.
// Optional build macro APB_PPROT_CHECK_EN: the upper half of the register
// space accepts only privileged accesses (PPROT[0]=1).
module apb4_slave_regfile #(
    parameter int                DATA_W      = 32,
    parameter int                ADDR_W      = 32,
    parameter int                DEPTH       = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                WAIT_STATES = 0
) (
    input  logic                clk,
    input  logic                RESET,
    input  logic [ADDR_W-1:0]   PADDR,
    input  logic [DATA_W-1:0]   PWDATA,
    input  logic                PWRITE,
    input  logic                PSELx,
    input  logic                PENABLE,
    input  logic [DATA_W/8-1:0] PSTRB,
    input  logic [2:0]          PPROT,
    output logic                PREADY,
    output logic [DATA_W-1:0]   PRDATA,
    output logic                PSLVERR
);

    localparam int                BYTES = DATA_W / 8;
    localparam int                LSB   = $clog2(BYTES);
    localparam int                IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] SPAN  = ADDR_W'(DEPTH * BYTES);
    localparam logic [3:0]        WS    = 4'(WAIT_STATES);

    // The setup phase is the capture edge out of IDLE; registered PREADY
    // must already be valid in the first access cycle when WS is zero.
    typedef enum logic {IDLE, ACCESS} state_t;

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 pready_q, pready_d;
    logic                 pslverr_q, pslverr_d;
    logic [DATA_W-1:0]    prdata_q, prdata_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 err_q, err_d;
    logic                 write_q, write_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [BYTES-1:0]     strb_q, strb_d;
    logic [DATA_W-1:0]    regs_q [DEPTH];
    logic [DATA_W-1:0]    regs_d [DEPTH];

    logic [ADDR_W-1:0]    off;
    logic [IDX_W-1:0]     idx_in;
    logic                 err_in;

    // Decode the bus address; the result is captured at the setup edge.
    always_comb begin
        off    = PADDR - BASE_ADDR;
        idx_in = off[LSB +: IDX_W];
        err_in = (PADDR < BASE_ADDR) || (off >= SPAN);
`ifdef APB_PPROT_CHECK_EN
        if (idx_in[IDX_W-1] && !PPROT[0]) err_in = 1'b1;
`endif
    end

`ifdef APB_PPROT_CHECK_EN
    logic unused_prot;
    assign unused_prot = ^PPROT[2:1];
`else
    logic unused_prot;
    assign unused_prot = ^PPROT;
`endif

    // Next-state: transfer sequencing, wait counter, read load, write commit.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = prdata_q;
        idx_d     = idx_q;
        err_d     = err_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        regs_d    = regs_q;
        case (state_q)
            IDLE: begin
                if (PSELx && !PENABLE) begin
                    idx_d   = idx_in;
                    err_d   = err_in;
                    write_d = PWRITE;
                    wdata_d = PWDATA;
                    strb_d  = PSTRB;
                    cnt_d   = WS;
                    state_d = ACCESS;
                    if (WS == 4'd0) begin
                        pready_d  = 1'b1;
                        pslverr_d = err_in;
                        if (!PWRITE) prdata_d = err_in ? '0 : regs_q[idx_in];
                    end
                end
            end
            ACCESS: begin
                if (!PSELx) begin
                    // Master abandoned the transfer: nothing commits.
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (pready_q) begin
                    state_d = IDLE;
                    if (PENABLE && write_q && !err_q) begin
                        for (int b = 0; b < BYTES; b++)
                            if (strb_q[b]) regs_d[idx_q][b*8 +: 8] = wdata_q[b*8 +: 8];
                    end
                end else if (cnt_q <= 4'd1) begin
                    cnt_d     = 4'd0;
                    pready_d  = 1'b1;
                    pslverr_d = err_q;
                    if (!write_q) prdata_d = err_q ? '0 : regs_q[idx_q];
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and register storage with asynchronous reset.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            idx_q     <= '0;
            err_q     <= 1'b0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            strb_q    <= '0;
            regs_q    <= '{default: '0};
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
            idx_q     <= idx_d;
            err_q     <= err_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            regs_q    <= regs_d;
        end
    end

    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;
    assign PRDATA  = prdata_q;

endmodule

// File: tb/tb_apb4_slave_regfile.sv
// Bench for apb4_slave_regfile: two instances (0 and 3 wait states) driven
// by randomized APB traffic and checked every cycle against a
// transaction-level model (register array + expected handshake timing).
module tb_apb4_slave_regfile;

`ifdef APB_PPROT_CHECK_EN
    localparam bit PPROT_EN = 1'b1;
`else
    localparam bit PPROT_EN = 1'b0;
`endif
    localparam int WS0 = 0;
    localparam int WS1 = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  psel = '0, penable = '0, pwrite = '0, pready, pslverr;
    logic [31:0] paddr [2];
    logic [31:0] pwdata [2];
    logic [3:0]  pstrb [2];
    logic [2:0]  pprot [2];
    logic [31:0] prdata [2];

    // model state
    logic [31:0] mem [2][16];
    logic [1:0]  exp_ready = '0, exp_err = '0;
    logic [31:0] exp_rdata [2];
    bit          chk_en = 1'b0;
    int          errors = 0, checks = 0;

    always #5 clk = ~clk;

    apb4_slave_regfile #(.DATA_W(32), .ADDR_W(32), .DEPTH(16), .BASE_ADDR(32'h0), .WAIT_STATES(WS0)) u_dut0 (
        .clk(clk), .RESET(rst), .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PWRITE(pwrite[0]),
        .PSELx(psel[0]), .PENABLE(penable[0]), .PSTRB(pstrb[0]), .PPROT(pprot[0]),
        .PREADY(pready[0]), .PRDATA(prdata[0]), .PSLVERR(pslverr[0]));

    apb4_slave_regfile #(.DATA_W(32), .ADDR_W(32), .DEPTH(16), .BASE_ADDR(32'h0), .WAIT_STATES(WS1)) u_dut1 (
        .clk(clk), .RESET(rst), .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PWRITE(pwrite[1]),
        .PSELx(psel[1]), .PENABLE(penable[1]), .PSTRB(pstrb[1]), .PPROT(pprot[1]),
        .PREADY(pready[1]), .PRDATA(prdata[1]), .PSLVERR(pslverr[1]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                check($sformatf("pready_u%0d", d), 32'(pready[d]), 32'(exp_ready[d]));
                check($sformatf("pslverr_u%0d", d), 32'(pslverr[d]), 32'(exp_err[d]));
                check($sformatf("prdata_u%0d", d), prdata[d], exp_rdata[d]);
            end
        end
    end

    function automatic logic model_err(input logic [31:0] a, input logic [2:0] p);
        return (a >= 32'd64) || (PPROT_EN && a[5] && !p[0]);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) mem[d][i] = '0;
            exp_rdata[d] = '0;
        end
        exp_ready = '0;
        exp_err   = '0;
    endtask

    // One APB transfer; called at posedge+1, returns at posedge+1.
    task automatic xfer(input int d, input logic [31:0] a, input logic [31:0] wd, input logic w,
                        input logic [3:0] s, input logic [2:0] p,
                        output logic [31:0] rd, output logic er);
        int  ws  = (d == 0) ? WS0 : WS1;
        logic e  = model_err(a, p);
        int  idx = int'(a[5:2]);
        rd = '0; er = 1'b0;
        psel[d] = 1'b1; penable[d] = 1'b0; paddr[d] = a; pwdata[d] = wd;
        pwrite[d] = w; pstrb[d] = s; pprot[d] = p;
        @(posedge clk); #1;
        penable[d] = 1'b1;
        for (int k = 1; k <= ws + 1; k++) begin
            if (k == ws + 1) begin
                exp_ready[d] = 1'b1;
                exp_err[d]   = e;
                if (!w) exp_rdata[d] = e ? 32'h0 : mem[d][idx];
            end
            @(negedge clk);
            if (k == ws + 1) begin rd = prdata[d]; er = pslverr[d]; end
            @(posedge clk);
            if (k == ws + 1 && w && !e)
                for (int b = 0; b < 4; b++)
                    if (s[b]) mem[d][idx][b*8 +: 8] = wd[b*8 +: 8];
            #1;
        end
        exp_ready[d] = 1'b0; exp_err[d] = 1'b0;
        psel[d] = 1'b0; penable[d] = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        psel = '0; penable = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        logic [31:0] rd, a;
        logic        er;
        int          d;
        for (int i = 0; i < 2; i++) begin
            paddr[i] = '0; pwdata[i] = '0; pstrb[i] = '0; pprot[i] = '0; exp_rdata[i] = '0;
        end
        model_reset();
        @(posedge clk); #1;
        chk_en = 1'b1;
        do_reset();
        check("reset_prdata", prdata[0], 32'h0);

        // all registers read back zero after reset
        for (int i = 0; i < 16; i++) begin
            xfer(0, 32'(i * 4), 32'h0, 1'b0, 4'h0, 3'b000, rd, er);
            if (i == 0 || i == 15) begin
                check($sformatf("t1_rd%0d", i), rd, 32'h0);
                check($sformatf("t1_err%0d", i), 32'(er), 32'h0);
            end
        end

        // byte strobes
        xfer(0, 32'h08, 32'hDEADBEEF, 1'b1, 4'b1111, 3'b001, rd, er);
        xfer(0, 32'h08, 32'h00000055, 1'b1, 4'b0001, 3'b001, rd, er);
        xfer(0, 32'h08, 32'h0, 1'b0, 4'h0, 3'b001, rd, er);
        check("t2_strb", rd, 32'hDEADBE55);
        xfer(0, 32'h08, 32'hFFFFFFFF, 1'b1, 4'b0000, 3'b001, rd, er);
        check("t2_nostrb_err", 32'(er), 32'h0);
        xfer(0, 32'h0B, 32'h0, 1'b0, 4'h0, 3'b001, rd, er);
        check("t2_nostrb_rd", rd, 32'hDEADBE55);

        // wait states
        xfer(1, 32'h04, 32'h12345678, 1'b1, 4'hF, 3'b001, rd, er);
        xfer(1, 32'h04, 32'h0, 1'b0, 4'h0, 3'b001, rd, er);
        check("t3_ws_rd", rd, 32'h12345678);

        // out of range
        xfer(0, 32'h40, 32'hCAFEF00D, 1'b1, 4'hF, 3'b001, rd, er);
        check("t4_wr_err", 32'(er), 32'h1);
        xfer(0, 32'h40, 32'h0, 1'b0, 4'h0, 3'b001, rd, er);
        check("t4_rd_err", 32'(er), 32'h1);
        check("t4_rd_zero", rd, 32'h0);
        xfer(0, 32'h00, 32'h0, 1'b0, 4'h0, 3'b001, rd, er);
        check("t4_reg0", rd, 32'h0);
        xfer(0, 32'h08, 32'h0, 1'b0, 4'h0, 3'b001, rd, er);
        check("t4_reg2", rd, 32'hDEADBE55);

        // privilege on the upper half
        xfer(0, 32'h20, 32'h1, 1'b1, 4'hF, 3'b000, rd, er);
        check("t6_unpriv_err", 32'(er), 32'(PPROT_EN));
        xfer(0, 32'h20, 32'h0, 1'b0, 4'h0, 3'b001, rd, er);
        check("t6_unpriv_rd", rd, PPROT_EN ? 32'h0 : 32'h1);
        xfer(0, 32'h20, 32'h1, 1'b1, 4'hF, 3'b001, rd, er);
        check("t6_priv_err", 32'(er), 32'h0);
        xfer(0, 32'h20, 32'h0, 1'b0, 4'h0, 3'b001, rd, er);
        check("t6_priv_rd", rd, 32'h1);

        // PENABLE without a setup phase is ignored
        psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1; paddr[0] = 32'h0; pwdata[0] = 32'hFFFF_FFFF; pstrb[0] = 4'hF;
        repeat (3) @(posedge clk);
        #1 psel[0] = 1'b0; penable[0] = 1'b0;
        xfer(0, 32'h00, 32'h0, 1'b0, 4'h0, 3'b001, rd, er);
        check("t5_noset_rd", rd, 32'h0);

        // master drops PSELx mid-access: no write
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 32'h0C; pwdata[1] = 32'h77777777; pstrb[1] = 4'hF;
        @(posedge clk); #1 penable[1] = 1'b1;
        @(posedge clk); #1 psel[1] = 1'b0; penable[1] = 1'b0;
        @(posedge clk); #1;
        xfer(1, 32'h0C, 32'h0, 1'b0, 4'h0, 3'b001, rd, er);
        check("abort_rd", rd, 32'h0);

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            d = int'($urandom_range(0, 1));
            a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 79));
            xfer(d, a, $urandom, 1'($urandom), 4'($urandom), 3'($urandom), rd, er);
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end

        // reset in the middle of a waited write
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 32'h10; pwdata[1] = 32'hA5A5A5A5; pstrb[1] = 4'hF;
        @(posedge clk); #1 penable[1] = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
        #1;
        check("t5_rst_ready", 32'(pready[1]), 32'h0);
        check("t5_rst_rdata", prdata[1], 32'h0);
        psel = '0; penable = '0;
        @(posedge clk); #1 rst = 1'b0;
        xfer(1, 32'h10, 32'h0, 1'b0, 4'h0, 3'b001, rd, er);
        check("t5_rst_rd", rd, 32'h0);

        repeat (2) @(posedge clk);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
